// File: rtl/pixel_frame_writer_if.sv
// Pixel-stream sink handshake and result-RAM write port of pixel_frame_writer.
interface pixel_frame_writer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
);
    logic              pix_valid;
    logic [DATA_W-1:0] pix_in;
    logic              pix_ready;
    logic              mem_grant;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;

    // Pixel source and memory model side.
    modport master (
        output pix_valid,
        output pix_in,
        input  pix_ready,
        output mem_grant,
        input  mem_we,
        input  mem_addr,
        input  mem_dout
    );

    // Frame writer side.
    modport slave (
        input  pix_valid,
        input  pix_in,
        output pix_ready,
        input  mem_grant,
        output mem_we,
        output mem_addr,
        output mem_dout
    );
endinterface

// File: rtl/pixel_frame_writer.sv
// Buffers processed pixels and writes one frame in raster order to the result RAM.
// Optional FRAME_CHECKSUM_EN adds a 16-bit running sum of the written pixels.
module pixel_frame_writer #(
    parameter int unsigned IMG_W      = 256,
    parameter int unsigned IMG_H      = 256,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    pixel_frame_writer_if.slave  bus,
    output logic                 Busy,
    output logic                 Complete
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);

    localparam int unsigned Frame = IMG_W * IMG_H;
    localparam int unsigned CntW  = ADDR_W + 1;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CntW-1:0] FrameCnt = CntW'(Frame);
    localparam logic [CntW-1:0] LastCnt  = CntW'(Frame - 1);
    localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr;
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW:0]     fifo_count;
    logic [CntW-1:0]   accept_cnt;
    logic [CntW-1:0]   wr_cnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              pix_ready;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

`ifdef FRAME_CHECKSUM_EN
    logic [15:0]       sum;
    assign checksum = sum;
`endif

    // Ready depends only on registered state, so the source may wait on it.
    assign pix_ready = (state == StRun) && (fifo_count < DepthCnt) && (accept_cnt < FrameCnt);
    assign push      = bus.pix_valid && pix_ready;
    assign pop       = (state == StRun) && (fifo_count != '0) && bus.mem_grant;
    assign head      = fifo_mem[rd_ptr];

    assign bus.pix_ready = pix_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_dout  = mem_dout;

    // Storage needs no reset: occupancy is tracked by fifo_count alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.pix_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= StIdle;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            accept_cnt <= '0;
            wr_cnt     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_dout   <= '0;
            Busy       <= 1'b0;
            Complete   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (Start) begin
                        state      <= StRun;
                        rd_ptr     <= '0;
                        wr_ptr     <= '0;
                        fifo_count <= '0;
                        accept_cnt <= '0;
                        wr_cnt     <= '0;
                        Busy       <= 1'b1;
                        Complete   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                StRun: begin
                    if (push) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        accept_cnt <= accept_cnt + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr   <= rd_ptr + 1'b1;
                        mem_we   <= 1'b1;
                        mem_dout <= head;
                        mem_addr <= wr_cnt[ADDR_W-1:0];
                        wr_cnt   <= wr_cnt + 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        sum      <= sum + 16'(head);
`endif
                        // Final write of the frame: Complete rises with this mem_we pulse.
                        if (wr_cnt == LastCnt) begin
                            state    <= StDone;
                            Busy     <= 1'b0;
                            Complete <= 1'b1;
                        end
                    end
                    case ({push, pop})
                        2'b10:   fifo_count <= fifo_count + 1'b1;
                        2'b01:   fifo_count <= fifo_count - 1'b1;
                        default: fifo_count <= fifo_count;
                    endcase
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Self-checking bench for pixel_frame_writer with a 4x4 frame and a 4-entry FIFO.
module tb_pixel_frame_writer;

    localparam int unsigned W     = 4;
    localparam int unsigned H     = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = W * H;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Start = 1'b0;
    logic Busy;
    logic Complete;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    pixel_frame_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    pixel_frame_writer #(
        .IMG_W      (W),
        .IMG_H      (H),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .bus      (bus),
        .Busy     (Busy),
        .Complete (Complete)
`ifdef FRAME_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame progress as plain counts of accepted and written pixels.
    bit          m_run;
    bit          m_complete;
    int          m_acc;
    int          m_wr;
    logic [7:0]  m_pix [FRAME];
    logic [15:0] m_sum;
    logic [7:0]  img [FRAME];
    int          wr_total;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       st;
        logic       e_we;
        logic [3:0] e_addr;
        logic [7:0] e_data;
        logic       e_rdy;
        logic       e_busy;
        logic       e_comp;
    } vec_t;

    vec_t       tbl [19];
    logic       p;
    logic       v;
    logic       g;
    logic [7:0] cur;
    int         nxt;
    logic [7:0] src [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_run      = 1'b0;
        m_complete = 1'b0;
        m_acc      = 0;
        m_wr       = 0;
        m_sum      = '0;
        wr_total   = 0;
    endtask

    // Entered at posedge+1; asserts RST mid-cycle and checks outputs before any edge.
    task automatic do_reset();
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.mem_grant = 1'b0;
        Start         = 1'b0;
        RST           = 1'b1;
        #2;
        check("rst_pix_ready", 32'(bus.pix_ready), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_dout", 32'(bus.mem_dout), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_complete", 32'(Complete), 0);
`ifdef FRAME_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 0);
`endif
        @(posedge CLK);
        #3 RST = 1'b0;
        @(posedge CLK);
        #1;
        model_clear();
    endtask

    // One clock of stimulus, checked against the model.
    task automatic step(input logic vi, input logic [7:0] d, input logic gi, input logic st,
                        output logic pushed);
        logic       exp_rdy;
        logic       mpush;
        logic       mpop;
        logic [7:0] exp_d;
        int         exp_a;
        bus.pix_valid = vi;
        bus.pix_in    = d;
        bus.mem_grant = gi;
        Start         = st;
        exp_rdy = m_run && ((m_acc - m_wr) < DEPTH) && (m_acc < FRAME);
        check("pix_ready", 32'(bus.pix_ready), 32'(exp_rdy));
        pushed = vi && (bus.pix_ready === 1'b1);
        mpush  = vi && exp_rdy;
        mpop   = m_run && (m_acc > m_wr) && gi;
        exp_a  = m_wr;
        exp_d  = mpop ? m_pix[m_wr] : 8'h00;
        @(posedge CLK);
        #1;
        if (m_run) begin
            if (mpush) begin
                m_pix[m_acc] = d;
                m_acc++;
            end
            if (mpop) begin
                m_wr++;
                m_sum = m_sum + 16'(exp_d);
                if (m_wr == FRAME) begin
                    m_run      = 1'b0;
                    m_complete = 1'b1;
                end
            end
        end else if (st) begin
            m_run      = 1'b1;
            m_complete = 1'b0;
            m_acc      = 0;
            m_wr       = 0;
            m_sum      = '0;
        end
        check("mem_we", 32'(bus.mem_we), 32'(mpop));
        if (mpop) begin
            check("mem_addr", 32'(bus.mem_addr), 32'(exp_a));
            check("mem_dout", 32'(bus.mem_dout), 32'(exp_d));
        end
        if (bus.mem_we === 1'b1) begin
            img[bus.mem_addr] = bus.mem_dout;
            wr_total++;
        end
        check("busy", 32'(Busy), 32'(m_run));
        check("complete", 32'(Complete), 32'(m_complete));
`ifdef FRAME_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(m_sum));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 19; i++) begin
            tbl[i].st     = (i == 0);
            tbl[i].v      = (i >= 1) && (i <= 16);
            tbl[i].d      = tbl[i].v ? 8'(i - 1) : 8'h00;
            tbl[i].e_we   = (i >= 2) && (i <= 17);
            tbl[i].e_addr = 4'(i - 2);
            tbl[i].e_data = 8'(i - 2);
            tbl[i].e_rdy  = (i <= 15);
            tbl[i].e_busy = (i <= 16);
            tbl[i].e_comp = (i >= 17);
        end
        model_clear();
        @(posedge CLK);
        #1;
        do_reset();

        // Directed back-to-back frame from the table.
        for (int i = 0; i < 19; i++) begin
            bus.pix_valid = tbl[i].v;
            bus.pix_in    = tbl[i].d;
            bus.mem_grant = 1'b1;
            Start         = tbl[i].st;
            @(posedge CLK);
            #1;
            check($sformatf("tbl%0d_we", i), 32'(bus.mem_we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                check($sformatf("tbl%0d_addr", i), 32'(bus.mem_addr), 32'(tbl[i].e_addr));
                check($sformatf("tbl%0d_data", i), 32'(bus.mem_dout), 32'(tbl[i].e_data));
            end
            check($sformatf("tbl%0d_rdy", i), 32'(bus.pix_ready), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_busy", i), 32'(Busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_comp", i), 32'(Complete), 32'(tbl[i].e_comp));
        end

        // Stall with mem_grant low, extra Start in RUN, then drain.
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1, p);
        nxt = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 8'(8'h40 + nxt), 1'b0, (c == 3), p);
            if (p) nxt++;
        end
        check("stall_accepted", nxt, DEPTH);
        check("stall_writes", wr_total, 0);
        for (int c = 0; c < 60 && Complete !== 1'b1; c++) begin
            step(nxt < FRAME, 8'(8'h40 + nxt), 1'b1, 1'b0, p);
            if (p) nxt++;
        end
        check("stall_complete", 32'(Complete), 1);
        check("stall_total_writes", wr_total, FRAME);
        for (int i = 0; i < FRAME; i++) begin
            check($sformatf("stall_img%0d", i), 32'(img[i]), 32'(8'h40 + i));
        end
        // Restart from DONE.
        step(1'b0, 8'h00, 1'b0, 1'b1, p);
        wr_total = 0;
        step(1'b1, 8'hA5, 1'b1, 1'b0, p);
        step(1'b0, 8'h00, 1'b1, 1'b0, p);
        check("restart_addr0", 32'(bus.mem_addr), 0);
        check("restart_data", 32'(bus.mem_dout), 32'h00A5);

        // Random valid/grant over a full frame.
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1, p);
        cur = 8'($urandom);
        for (int c = 0; c < 400 && Complete !== 1'b1; c++) begin
            v = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            step(v, cur, g, 1'b0, p);
            if (p) begin
                src.push_back(cur);
                cur = 8'($urandom);
            end
        end
        check("rand_complete", 32'(Complete), 1);
        check("rand_total_writes", wr_total, FRAME);
        check("rand_accepted", src.size(), FRAME);
        for (int i = 0; i < FRAME && i < src.size(); i++) begin
            check($sformatf("rand_img%0d", i), 32'(img[i]), 32'(src[i]));
        end
        // A 17th pixel is refused and never written.
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 8'h77, 1'b1, 1'b0, p);
        end
        check("extra_writes", wr_total, FRAME);

        // Abort mid-frame with 7 written and 3 buffered.
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1, p);
        nxt = 0;
        for (int c = 0; c < 100 && !(m_wr == 7 && (m_acc - m_wr) == 3); c++) begin
            step(1'b1, 8'(nxt), (m_wr < 7), 1'b0, p);
            if (p) nxt++;
        end
        check("abort_prefill_writes", wr_total, 7);
        check("abort_prefill_accepted", nxt, 10);
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 8'h33, 1'b1, 1'b0, p);
        end
        check("abort_no_writes", wr_total, 0);

`ifdef FRAME_CHECKSUM_EN
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1, p);
        nxt = 0;
        for (int c = 0; c < 60 && Complete !== 1'b1; c++) begin
            step(nxt < FRAME, 8'hFF, 1'b1, 1'b0, p);
            if (p) nxt++;
        end
        check("csum_complete", 32'(Complete), 1);
        check("csum_value", 32'(checksum), 32'h0FF0);
        step(1'b0, 8'h00, 1'b0, 1'b1, p);
        check("csum_cleared", 32'(checksum), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
